// File: rtl/entry_pkg.sv
// Shared widths, digit type and per-digit step helper for the button digit-entry block.
package entry_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_W      = NUM_DIGITS * DIGIT_W;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Modulo-16 increment (dec=0) or decrement (dec=1) of one hex digit.
  function automatic digit_t digit_step(input digit_t d, input logic dec);
    if (dec) return d - digit_t'(1);
    return d + digit_t'(1);
  endfunction

endpackage

// File: rtl/btn_digit_entry_if.sv
// Button/switch inputs and number/press outputs of the digit-entry block.
interface btn_digit_entry_if;
  import entry_pkg::*;

  logic [NUM_DIGITS-1:0] btn;
  logic                  dir;
  logic                  clr;
  logic [NUM_W-1:0]      num;
  logic [NUM_DIGITS-1:0] press;

  modport master (output btn, output dir, output clr, input num, input press);
  modport slave  (input btn, input dir, input clr, output num, output press);

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level and rise detect.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             db;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;

  // Any return of the synced level to db restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = db;
  assign rise  = db & ~db_prev;

endmodule

// File: rtl/btn_digit_entry.sv
// Hex-number entry: each debounced button press steps one display digit up or down.
module btn_digit_entry
  import entry_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [NUM_W-1:0] INIT_VALUE      = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  btn_digit_entry_if.slave  bus
);

  logic [NUM_DIGITS-1:0] rise;
  logic [NUM_DIGITS-1:0] level_unused;
  logic [NUM_W-1:0]      num_next;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn[i]),
      .level (level_unused[i]),
      .rise  (rise[i])
    );
  end

  // Digits step independently; no carry or borrow between them.
  always_comb begin
    num_next = bus.num;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (rise[i]) begin
        num_next[i*DIGIT_W +: DIGIT_W] = digit_step(bus.num[i*DIGIT_W +: DIGIT_W], bus.dir);
      end
    end
  end

  // Clear wins over presses for num, but press still reports the accepted rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.num   <= INIT_VALUE;
      bus.press <= '0;
    end else begin
      bus.press <= rise;
      bus.num   <= bus.clr ? INIT_VALUE : num_next;
    end
  end

endmodule

// File: tb/tb_btn_digit_entry.sv
// Scoreboard bench for btn_digit_entry with DEBOUNCE_CYCLES=4.
module tb_btn_digit_entry;

  localparam int unsigned DB      = 4;
  localparam int unsigned LATENCY = DB + 3;

  typedef struct {
    logic [3:0]  press;
    logic [15:0] num;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];

  btn_digit_entry_if bus();

  btn_digit_entry #(
    .DEBOUNCE_CYCLES (DB),
    .INIT_VALUE      (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with a press pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.press != 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_press: press=%b num=%h cyc=%0d, required no press", bus.press, bus.num, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.press !== e.press || bus.num !== e.num || cyc != e.cyc) begin
          failures++;
          $display("FAIL press_event: press=%b num=%h cyc=%0d, required press=%b num=%h cyc=%0d",
                   bus.press, bus.num, cyc, e.press, e.num, e.cyc);
        end
      end
    end
  end

  task automatic check_num(input string name, input logic [15:0] want);
    checks++;
    if (bus.num !== want) begin
      failures++;
      $display("FAIL %s: num=%h, required %h", name, bus.num, want);
    end
  endtask

  // Press mask with direction; optionally assert clr on exactly the rise edge.
  task automatic do_press(input logic [3:0] mask, input logic d, input logic [15:0] want_num,
                          input logic clr_on_rise, input string name);
    exp_t e;
    bus.dir = d;
    bus.btn = mask;
    e.press = mask;
    e.num   = want_num;
    e.cyc   = cyc + LATENCY;
    q.push_back(e);
    repeat (LATENCY - 1) @(negedge clk);
    if (clr_on_rise) bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    bus.btn = 4'b0000;
    repeat (12) @(negedge clk);
    check_num(name, want_num);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic        d;
    logic [15:0] num;
  } vec_t;

  vec_t build[10];

  initial begin
    rst     = 1'b1;
    bus.btn = 4'hF;
    bus.dir = 1'b0;
    bus.clr = 1'b0;

    // Reset held 3 cycles with all buttons pressed.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_num("reset_num", 16'h0000);
      checks++;
      if (bus.press !== 4'b0000) begin
        failures++;
        $display("FAIL reset_press: press=%b, required 0000", bus.press);
      end
    end
    rst = 1'b0;
    begin
      exp_t e;
      e.press = 4'hF;
      e.num   = 16'h1111;
      e.cyc   = cyc + LATENCY;
      q.push_back(e);
    end
    repeat (LATENCY + 3) @(negedge clk);
    bus.btn = 4'b0000;
    repeat (12) @(negedge clk);
    check_num("held_through_reset", 16'h1111);

    // clr alone, latency 1.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_num("clr_alone", 16'h0000);

    do_press(4'b0100, 1'b0, 16'h0100, 1'b0, "single_press");

    // Bounce: high 3, low 1, high 2, low.
    bus.btn = 4'b0001; repeat (3) @(negedge clk);
    bus.btn = 4'b0000; @(negedge clk);
    bus.btn = 4'b0001; repeat (2) @(negedge clk);
    bus.btn = 4'b0000; repeat (15) @(negedge clk);
    check_num("bounce", 16'h0100);

    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_num("clr_before_wrap", 16'h0000);
    do_press(4'b0001, 1'b1, 16'h000F, 1'b0, "wrap_down");
    do_press(4'b0001, 1'b0, 16'h0000, 1'b0, "wrap_up");

    // Build 1234 with parallel presses, then the simultaneous pair.
    build[0] = '{4'b1111, 1'b0, 16'h1111};
    build[1] = '{4'b0111, 1'b0, 16'h1222};
    build[2] = '{4'b0011, 1'b0, 16'h1233};
    build[3] = '{4'b0001, 1'b0, 16'h1234};
    build[4] = '{4'b1010, 1'b0, 16'h2244};
    for (int i = 0; i < 5; i++) do_press(build[i].mask, build[i].d, build[i].num, 1'b0, "multi_press");

    // Reach ABCD by decrementing from zero.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    build[5] = '{4'b1111, 1'b1, 16'hFFFF};
    build[6] = '{4'b1111, 1'b1, 16'hEEEE};
    build[7] = '{4'b1111, 1'b1, 16'hDDDD};
    build[8] = '{4'b1110, 1'b1, 16'hCCCD};
    build[9] = '{4'b1100, 1'b1, 16'hBBCD};
    for (int i = 5; i < 10; i++) do_press(build[i].mask, build[i].d, build[i].num, 1'b0, "dec_press");
    do_press(4'b1000, 1'b1, 16'hABCD, 1'b0, "dec_to_abcd");

    do_press(4'b1000, 1'b0, 16'h0000, 1'b1, "clr_priority");

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_press: %0d expected presses never seen, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
